// File: rtl/sdram_bist.sv
// sdram_bist: pattern write / read-back test engine for the sdram_controller3 user port.
// Writes every word of [START_ADDR, END_ADDR) at STRIDE, reads it back, and reports the result.
module sdram_bist #(
  parameter int          ADDR_W      = 24,
  parameter int          DATA_W      = 32,
  parameter int unsigned START_ADDR  = 'h1000,
  parameter int unsigned END_ADDR    = 'h1100,
  parameter int unsigned STRIDE      = 4,
  parameter logic [31:0] LFSR_TAPS   = 32'h00400007,
  parameter logic [31:0] SEED        = 32'd1,
  parameter int unsigned TIMEOUT     = 1023,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_expected,
  output logic [DATA_W-1:0] err_actual,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic              req_write,
  output logic              req_read,
  input  logic              write_complete,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_out
);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W:0] START_X = (ADDR_W+1)'(START_ADDR);
  localparam logic [ADDR_W:0] END_X = (ADDR_W+1)'(END_ADDR);
  localparam logic [ADDR_W:0] STRIDE_X = (ADDR_W+1)'(STRIDE);
  localparam bit EMPTY = END_X <= START_X;
  localparam logic [DATA_W-1:0] SEED_V = (DATA_W'(SEED) == '0) ? DATA_W'(1) : DATA_W'(SEED);
  localparam logic [DATA_W-1:0] TAPS_V = DATA_W'(LFSR_TAPS);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]     bidx_q, bidx_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              wc_q, dv_q;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [DATA_W-1:0] err_expected_q, err_expected_d, err_actual_q, err_actual_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              req_write_q, req_write_d, req_read_q, req_read_d;

  logic [ADDR_W+DATA_W-1:0] wide;
  logic [DATA_W-1:0]        pat, lfsr_nx;
  logic [BW-1:0]            bidx_nx;
  logic [ADDR_W:0]          sum;
  logic                     last, wc_edge, dv_edge, mism, fin;

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign err_count    = err_count_q;
  assign err_addr     = err_addr_q;
  assign err_expected = err_expected_q;
  assign err_actual   = err_actual_q;
  assign address      = address_q;
  assign data_in      = data_in_q;
  assign req_write    = req_write_q;
  assign req_read     = req_read_q;

  // Pattern for the current word; the read phase regenerates it from the same address/index/LFSR state.
  always_comb begin
    wide = {{DATA_W{1'b0}}, addr_q};
    wide = wide | (wide << (DATA_W / 2));
    pat = (mode_q == 2'd0) ? wide[DATA_W-1:0] :
          (mode_q == 2'd1) ? ~wide[DATA_W-1:0] :
          (mode_q == 2'd2) ? (DATA_W'(1) << bidx_q) : lfsr_q;
    lfsr_nx = {lfsr_q[DATA_W-2:0], 1'b0} ^ (lfsr_q[DATA_W-1] ? TAPS_V : '0);
    bidx_nx = (bidx_q == BW'(DATA_W - 1)) ? '0 : bidx_q + BW'(1);
    sum = {1'b0, addr_q} + STRIDE_X;
    last = sum >= END_X;
    wc_edge = write_complete & ~wc_q;
    dv_edge = data_valid & ~dv_q;
    mism = data_out != pat;
  end

  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    addr_d = addr_q;
    bidx_d = bidx_q;
    lfsr_d = lfsr_q;
    tcnt_d = tcnt_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    fail_d = fail_q;
    timeout_d = timeout_q;
    err_count_d = err_count_q;
    err_addr_d = err_addr_q;
    err_expected_d = err_expected_q;
    err_actual_d = err_actual_q;
    address_d = address_q;
    data_in_d = data_in_q;
    req_write_d = 1'b0;
    req_read_d = 1'b0;
    fin = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        mode_d = mode;
        addr_d = START_X[ADDR_W-1:0];
        bidx_d = '0;
        lfsr_d = SEED_V;
        err_count_d = '0;
        err_addr_d = '0;
        err_expected_d = '0;
        err_actual_d = '0;
        timeout_d = 1'b0;
        fail_d = 1'b0;
        done_d = EMPTY;
        pass_d = EMPTY;
        busy_d = !EMPTY;
        state_d = EMPTY ? DONE : WR_REQ;
      end
      WR_REQ, RD_REQ: begin
        address_d = addr_q;
        data_in_d = (state_q == WR_REQ) ? pat : data_in_q;
        req_write_d = state_q == WR_REQ;
        req_read_d = state_q == RD_REQ;
        tcnt_d = '0;
        state_d = (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
      end
      WR_WAIT, RD_WAIT: if (state_q == WR_WAIT ? wc_edge : dv_edge) begin
        if (state_q == RD_WAIT && mism) begin
          err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
          if (err_count_q == '0) begin
            err_addr_d = addr_q;
            err_expected_d = pat;
            err_actual_d = data_out;
          end
        end
        fin = state_q == RD_WAIT && (last || (mism && STOP_ON_ERR));
        // The write phase wraps back to the first word with a fresh LFSR for read-back.
        addr_d = last ? START_X[ADDR_W-1:0] : sum[ADDR_W-1:0];
        bidx_d = last ? '0 : bidx_nx;
        lfsr_d = last ? SEED_V : lfsr_nx;
        state_d = fin ? DONE : (state_q == RD_WAIT || last) ? RD_REQ : WR_REQ;
        done_d = fin;
        busy_d = !fin;
        pass_d = fin && err_count_d == '0;
        fail_d = fin && err_count_d != '0;
      end else if (tcnt_q == TLIM) begin
        timeout_d = 1'b1;
        done_d = 1'b1;
        fail_d = 1'b1;
        pass_d = 1'b0;
        busy_d = 1'b0;
        state_d = DONE;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q <= '0;
      addr_q <= '0;
      bidx_q <= '0;
      lfsr_q <= '0;
      tcnt_q <= '0;
      wc_q <= 1'b0;
      dv_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      timeout_q <= 1'b0;
      err_count_q <= '0;
      err_addr_q <= '0;
      err_expected_q <= '0;
      err_actual_q <= '0;
      address_q <= '0;
      data_in_q <= '0;
      req_write_q <= 1'b0;
      req_read_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      addr_q <= addr_d;
      bidx_q <= bidx_d;
      lfsr_q <= lfsr_d;
      tcnt_q <= tcnt_d;
      wc_q <= write_complete;
      dv_q <= data_valid;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      timeout_q <= timeout_d;
      err_count_q <= err_count_d;
      err_addr_q <= err_addr_d;
      err_expected_q <= err_expected_d;
      err_actual_q <= err_actual_d;
      address_q <= address_d;
      data_in_q <= data_in_d;
      req_write_q <= req_write_d;
      req_read_q <= req_read_d;
    end
  end
endmodule

// File: tb/tb_sdram_bist.sv
// tb_sdram_bist: sdram_bist against a controller model with a word memory and a
// transaction-level reference of the expected request stream.
module tb_sdram_bist;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic start = 1'b0, start_s = 1'b0, start_e = 1'b0;
  logic [1:0] mode = 2'd0;
  logic fault_en = 1'b0, wc_block = 1'b0;

  logic busy, done, pass, fail, timeout, req_write, req_read;
  logic [15:0] err_count;
  logic [23:0] err_addr, address;
  logic [31:0] err_expected, err_actual, data_in;
  logic write_complete = 1'b0, data_valid = 1'b0;
  logic [31:0] data_out = '0;

  logic busy_s, done_s, pass_s, fail_s, timeout_s, req_write_s, req_read_s;
  logic [15:0] err_count_s;
  logic [23:0] err_addr_s, address_s;
  logic [31:0] err_expected_s, err_actual_s, data_in_s;
  logic write_complete_s = 1'b0, data_valid_s = 1'b0;
  logic [31:0] data_out_s = '0;

  logic busy_e, done_e, pass_e, fail_e, timeout_e, req_write_e, req_read_e;
  logic [15:0] err_count_e;
  logic [23:0] err_addr_e, address_e;
  logic [31:0] err_expected_e, err_actual_e, data_in_e;

  sdram_bist u_dut (
    .CLOCK_50(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .err_count(err_count), .err_addr(err_addr), .err_expected(err_expected), .err_actual(err_actual),
    .address(address), .data_in(data_in), .req_write(req_write), .req_read(req_read),
    .write_complete(write_complete), .data_valid(data_valid), .data_out(data_out));

  sdram_bist #(.STOP_ON_ERR(1'b1)) u_stop (
    .CLOCK_50(clk), .rst_n(rst_n), .start(start_s), .mode(mode),
    .busy(busy_s), .done(done_s), .pass(pass_s), .fail(fail_s), .timeout(timeout_s),
    .err_count(err_count_s), .err_addr(err_addr_s), .err_expected(err_expected_s), .err_actual(err_actual_s),
    .address(address_s), .data_in(data_in_s), .req_write(req_write_s), .req_read(req_read_s),
    .write_complete(write_complete_s), .data_valid(data_valid_s), .data_out(data_out_s));

  sdram_bist #(.END_ADDR('h1000)) u_empty (
    .CLOCK_50(clk), .rst_n(rst_n), .start(start_e), .mode(mode),
    .busy(busy_e), .done(done_e), .pass(pass_e), .fail(fail_e), .timeout(timeout_e),
    .err_count(err_count_e), .err_addr(err_addr_e), .err_expected(err_expected_e), .err_actual(err_actual_e),
    .address(address_e), .data_in(data_in_e), .req_write(req_write_e), .req_read(req_read_e),
    .write_complete(1'b0), .data_valid(1'b0), .data_out(32'h0));

  int n_vec = 0, n_err = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: the word list and its pattern, straight from the address range and mode rules.
  logic [23:0] exp_a[64];
  logic [31:0] exp_d[64], cap_d[64];
  int n_exp = 0;

  function automatic logic [31:0] pat0(input int a);
    logic [63:0] t;
    t = 64'(a) | (64'(a) << 16);
    return t[31:0];
  endfunction

  task automatic build(input logic [1:0] m);
    logic [31:0] x;
    int k;
    x = 32'd1;
    k = 0;
    for (int a = 'h1000; a < 'h1100; a += 4) begin
      exp_a[k] = 24'(a);
      exp_d[k] = (m == 2'd0) ? pat0(a) : (m == 2'd1) ? ~pat0(a) : (m == 2'd2) ? (32'd1 << (k % 32)) : x;
      x = {x[30:0], 1'b0} ^ (x[31] ? 32'h00400007 : 32'h0);
      k++;
    end
    n_exp = k;
  endtask

  // Controller model: completion pulse three cycles after each request.
  logic [31:0] mem[logic [23:0]];
  logic [23:0] ra;
  int wt = 0, rt = 0;
  always @(negedge clk) begin
    write_complete = 1'b0;
    data_valid = 1'b0;
    if (!rst_n) begin
      wt = 0;
      rt = 0;
    end else begin
      if (req_write) begin
        wt = 3;
        mem[address] = data_in;
      end else if (wt > 0) begin
        wt--;
        if (wt == 0 && !wc_block) write_complete = 1'b1;
      end
      if (req_read) begin
        rt = 3;
        ra = address;
      end else if (rt > 0) begin
        rt--;
        if (rt == 0) begin
          data_out = mem[ra] ^ ((fault_en && ra == 24'h1040) ? 32'd1 : 32'd0);
          data_valid = 1'b1;
        end
      end
    end
  end

  logic [31:0] mem_s[logic [23:0]];
  logic [23:0] ra_s;
  int wt_s = 0, rt_s = 0, rd_s = 0;
  always @(negedge clk) begin
    write_complete_s = 1'b0;
    data_valid_s = 1'b0;
    if (req_write_s) begin
      wt_s = 3;
      mem_s[address_s] = data_in_s;
    end else if (wt_s > 0) begin
      wt_s--;
      if (wt_s == 0) write_complete_s = 1'b1;
    end
    if (req_read_s) begin
      rt_s = 3;
      ra_s = address_s;
      rd_s++;
    end else if (rt_s > 0) begin
      rt_s--;
      if (rt_s == 0) begin
        data_out_s = mem_s[ra_s] ^ ((ra_s == 24'h1040) ? 32'd1 : 32'd0);
        data_valid_s = 1'b1;
      end
    end
  end

  logic req_seen_e = 1'b0;
  always @(negedge clk) if (req_write_e || req_read_e) req_seen_e = 1'b1;

  // Compare process: every request against the reference word list.
  int wi = 0, ri = 0, fw_cyc = 0;
  logic rw_prev = 1'b0, rr_prev = 1'b0;
  always @(negedge clk) begin
    if (start) begin
      wi = 0;
      ri = 0;
    end
    if (req_write || req_read) begin
      chk("req_excl", {req_write, req_read}, (req_write ? 64'd2 : 64'd1));
      chk("busy_on_req", busy, 1);
    end
    if (req_write) begin
      chk("wr_pulse", rw_prev, 0);
      if (wi < n_exp) begin
        chk("wr_addr", address, exp_a[wi]);
        chk("wr_data", data_in, exp_d[wi]);
        cap_d[wi] = data_in;
      end else chk("extra_write", wi, n_exp);
      if (wi == 0) fw_cyc = cyc;
      wi++;
    end
    if (req_read) begin
      chk("rd_pulse", rr_prev, 0);
      chk("rd_after_writes", wi, n_exp);
      if (ri < n_exp) chk("rd_addr", address, exp_a[ri]);
      else chk("extra_read", ri, n_exp);
      ri++;
    end
    rw_prev = req_write;
    rr_prev = req_read;
  end

  task automatic pulse_main();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lim);
    for (int c = 0; c < lim && !done; c++) @(negedge clk);
    chk(nm, done, 1);
  endtask

  task automatic run_clean(input logic [1:0] m, input string nm);
    mode = m;
    build(m);
    pulse_main();
    wait_done(nm, 3000);
    chk({nm, "_pass"}, {pass, fail, timeout}, 3'b100);
    chk({nm, "_errs"}, err_count, 0);
    chk({nm, "_writes"}, wi, 64);
    chk({nm, "_reads"}, ri, 64);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_flags", {busy, done, pass, fail, timeout, req_write, req_read, err_count}, 0);
    chk("rst_addr", {err_addr, address}, 0);
    chk("rst_data", err_expected | err_actual | data_in, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_clean(2'd0, "mode0");
    chk("mode0_first", cap_d[0], 32'h10001000);
    chk("mode0_w16", cap_d[16], 32'h10401040);

    fault_en = 1'b1;
    build(2'd0);
    pulse_main();
    chk("start_clears_done", {done, busy}, 2'b01);
    wait_done("fault_done", 3000);
    chk("fault_flags", {pass, fail, timeout}, 3'b010);
    chk("fault_count", err_count, 1);
    chk("fault_addr", err_addr, 24'h1040);
    chk("fault_exp", err_expected, 32'h10401040);
    chk("fault_act", err_actual, 32'h10401041);
    chk("fault_reads", ri, 64);
    fault_en = 1'b0;

    run_clean(2'd1, "mode1");
    chk("mode1_first", cap_d[0], 32'hEFFFEFFF);
    run_clean(2'd2, "mode2");
    chk("mode2_w33", cap_d[33], 32'h00000002);
    run_clean(2'd3, "mode3");
    chk("mode3_w1", cap_d[1], 32'h00000002);
    chk("mode3_w31", cap_d[31], 32'h80000000);
    chk("mode3_w32", cap_d[32], 32'h00400007);

    wc_block = 1'b1;
    mode = 2'd0;
    build(2'd0);
    pulse_main();
    wait_done("to_done", 1500);
    chk("to_flags", {timeout, fail, pass}, 3'b110);
    chk("to_latency", cyc - fw_cyc, 1023);
    repeat (20) @(negedge clk);
    chk("to_no_more_req", wi + ri, 1);
    wc_block = 1'b0;

    pulse_main();
    for (int c = 0; c < 3000 && ri < 5; c++) @(negedge clk);
    chk("reached_read", ri, 5);
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {busy, done, pass, fail, timeout, req_write, req_read, err_count}, 0);
    chk("abort_addr", {err_addr, address}, 0);
    chk("abort_data", err_expected | err_actual | data_in, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_clean(2'd0, "after_abort");

    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    for (int c = 0; c < 3000 && !done_s; c++) @(negedge clk);
    chk("stop_done", done_s, 1);
    chk("stop_flags", {pass_s, fail_s, timeout_s}, 3'b010);
    chk("stop_count", err_count_s, 1);
    chk("stop_addr", err_addr_s, 24'h1040);
    chk("stop_act", err_actual_s, 32'h10401041);
    chk("stop_reads", rd_s, 17);
    repeat (20) @(negedge clk);
    chk("stop_reads_after", rd_s, 17);

    chk("empty_pre", done_e, 0);
    @(negedge clk) start_e = 1'b1;
    @(negedge clk) start_e = 1'b0;
    chk("empty_done", {done_e, pass_e, fail_e, busy_e}, 4'b1100);
    repeat (5) @(negedge clk);
    chk("empty_no_req", req_seen_e, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
